// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: iterative AES inverse cipher, one round per clock.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    accept request, sampled only while idle
//   ct_in    128-bit ciphertext, byte 0 at [127:120], column-major
//   rk_idx   round-key index presented to key storage (NR..0)
//   rk_data  round key for rk_idx, combinational read, same layout as ct_in
//   busy     high while a block is in flight (NR cycles)
//   done     one-cycle completion pulse
//   pt_out   plaintext register, holds until the next completion
module aes_inv_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ct_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    localparam logic [3:0] NR_L = 4'(NR);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Byte (row r, column c) lives at index 4c+r; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*((c+r)%4)+r) -: 8] = inv_sbox(s[127-8*(4*c+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Stands in for the istate/ostate InvMixColumns block.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] istate);
        logic [127:0] ostate;
        for (int c = 0; c < 4; c++) begin
            ostate[127-32*c -: 32] = inv_mix_col(istate[127-32*c -: 32]);
        end
        return ostate;
    endfunction

    logic [1:0]   fsm;
    logic [3:0]   rnd;
    logic [127:0] state_reg;
    logic [127:0] keyed;
    logic [127:0] round_out;

    always_comb begin
        case (fsm)
            IDLE:    rk_idx = NR_L;
            ROUND:   rk_idx = rnd;
            FINAL:   rk_idx = 4'd0;
            default: rk_idx = NR_L;
        endcase
    end

    // Shared by ROUND (then InvMixColumns) and FINAL (used directly).
    assign keyed     = inv_shift_sub(state_reg) ^ rk_data;
    assign round_out = inv_mix_columns(keyed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            rnd       <= 4'd0;
            state_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pt_out    <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state_reg <= ct_in ^ rk_data;
                        rnd       <= NR_L - 4'd1;
                        busy      <= 1'b1;
                        fsm       <= (NR > 1) ? ROUND : FINAL;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    rnd       <= rnd - 4'd1;
                    if (rnd == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    pt_out <= keyed;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    fsm    <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative AES decryption engine controller. It sequences one full inverse cipher over a single 128-bit block, one round per clock, through the combinational inverse round datapath: inverse ShiftRows, inverse SubBytes, AddRoundKey and the existing 128-bit inverse MixColumns block (istate/ostate). It sits between the SPI-side block buffer and the key-schedule storage. It fetches round keys by index, and signals completion with a start/busy/done handshake.

## Interface
- NR, default 10: number of rounds (10/12/14 for AES-128/192/256); round-key index runs NR..0.
- clk  input  1  rising-edge clock, single domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only while idle.
- ct_in  input  128  ciphertext; byte 0 at [127:120]; column c at [127-32c -: 32], row 0 in the MS byte of each column.
- rk_idx  output  4  round-key index presented to key storage.
- rk_data  input  128  round key for rk_idx, valid combinationally in the same cycle (same byte layout as ct_in).
- busy  output  1  high while a block is in flight.
- done  output  1  one-cycle completion pulse.
- pt_out  output  128  plaintext register; holds the last result until the next completion.

## Operation
- FSM states: IDLE, ROUND, FINAL. A 4-bit round counter `rnd` drives rk_idx.
- IDLE:
  - rk_idx = NR.
  - On start=1 at a clock edge: state_reg <= ct_in ^ rk_data; rnd <= NR-1; busy <= 1; go to ROUND (NR>1) or FINAL (NR=1).
  - Otherwise hold.
- ROUND:
  - rk_idx = rnd.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_data).
  - rnd <= rnd-1.
  - When rnd==1, go to FINAL (rnd becomes 0).
- FINAL:
  - rk_idx = 0.
  - pt_out <= InvSubBytes(InvShiftRows(state_reg)) ^ rk_data (no InvMixColumns).
  - done <= 1; busy <= 0; go to IDLE.
- start outside IDLE is ignored. No queuing, and no effect on the running block.
- ct_in is captured only at the accept edge. Later changes to ct_in do not affect the block in flight.
- rk_idx is a pure function of FSM state and rnd. It never exceeds NR and never goes below 0. rnd never wraps.
- Reset, including mid-operation: FSM=IDLE, rnd=0, busy=0, done=0, pt_out=0, state_reg=0. The in-flight block is discarded, with no done pulse. rk_idx=NR once reset is released.

## Timing
- Accept edge E0. Round edges E1..E(NR-1). Final edge E(NR).
- done=1 and pt_out valid during the cycle after E(NR). Latency from accept to done is NR clocks (10 for AES-128).
- busy rises after E0 and falls after E(NR). It is high for exactly NR cycles.
- done lasts exactly one cycle. The FSM is already IDLE during that cycle, so start=1 in the done cycle is accepted. Back-to-back throughput is one block per NR+1 cycles.
- pt_out changes only at a FINAL edge or at reset.
- rk_data is sampled at the same edge that uses it. Key storage must be combinational read (zero-cycle).

## Test plan
- FIPS-197 C.1, NR=10:
  - Stimulus: key model for key 000102030405060708090a0b0c0d0e0f; ct_in=69c4e0d86a7b0430d8cdb78070b4c55a; start 1 cycle.
  - Required: pt_out=00112233445566778899aabbccddeeff; done exactly 10 cycles after accept; rk_idx sequence 10,9,…,1,0.
- Reset values: rst_n=0 asynchronously mid-clock -> busy=0, done=0, pt_out=0 immediately, without waiting for a clock edge.
- Start while busy:
  - Stimulus: accept vector A; pulse start with vector B at round 5.
  - Required: B ignored; pt_out=A's plaintext; exactly one done.
- Back-to-back:
  - Stimulus: start held high continuously with ct_in switched after each accept.
  - Required: second accept occurs in the done cycle of the first; two correct plaintexts; done pulses 11 cycles apart.
- Reset mid-operation:
  - Stimulus: rst_n low for 1 cycle at round 4, then a new start.
  - Required: no done for the aborted block; new block completes correctly with full 10-cycle latency.
- Input stability: toggle ct_in every cycle after accept -> result still equals the plaintext of the value captured at E0.
